// File: rtl/fetch_decode_alu_core_if.sv
// Bus bundle for fetch_decode_alu_core.
// Groups the instruction-memory, register-file and EX-stage result signals.
//   master : the core side (drives imem_addr, rf_addr_*, ex_*, flags, branch_taken)
//   slave  : the environment side (drives imem_data, rf_data_*)
interface fetch_decode_alu_core_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [2:0]  rf_addr_a;
    logic [2:0]  rf_addr_b;
    logic [15:0] rf_data_a;
    logic [15:0] rf_data_b;
    logic        ex_valid;
    logic [15:0] ex_instr;
    logic [15:0] ex_result;
    logic        ex_wr_en;
    logic [2:0]  ex_wr_addr;
    logic        carry_flag;
    logic        zero_flag;
    logic        branch_taken;

    modport master (
        output imem_addr, rf_addr_a, rf_addr_b,
        output ex_valid, ex_instr, ex_result, ex_wr_en, ex_wr_addr,
        output carry_flag, zero_flag, branch_taken,
        input  imem_data, rf_data_a, rf_data_b
    );

    modport slave (
        input  imem_addr, rf_addr_a, rf_addr_b,
        input  ex_valid, ex_instr, ex_result, ex_wr_en, ex_wr_addr,
        input  carry_flag, zero_flag, branch_taken,
        output imem_data, rf_data_a, rf_data_b
    );
endinterface

// File: rtl/fetch_decode_alu_core.sv
// fetch_decode_alu_core: IF / ID / EX slice of the 16-bit pipelined RISC core.
//   IF : PC register, captures imem_data into IF/ID.
//   ID : presents RA/RB to the external register file, captures operands into ID/EX.
//   EX : ALU, C/Z flags, conditional execution, branch resolution; all ex_* registered.
// Ports:
//   clock  : single clock, posedge
//   reset  : asynchronous active-high, clears all state, PC <= RESET_PC
//   bus    : fetch_decode_alu_core_if.master (imem, register-file, EX results, flags)
module fetch_decode_alu_core #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                   clock,
    input  logic                   reset,
    fetch_decode_alu_core_if.master bus
);

    // Pipeline state
    logic [15:0] pc_r;
    logic [15:0] ifid_instr_r;
    logic [15:0] ifid_pc_r;
    logic        ifid_valid_r;
    logic [15:0] idex_instr_r;
    logic [15:0] idex_pc_r;
    logic [15:0] idex_a_r;
    logic [15:0] idex_b_r;
    logic        idex_valid_r;

    // Registered EX outputs and architectural flags
    logic        ex_valid_r;
    logic [15:0] ex_instr_r;
    logic [15:0] ex_result_r;
    logic        ex_wr_en_r;
    logic [2:0]  ex_wr_addr_r;
    logic        carry_r;
    logic        zero_r;
    logic        branch_taken_r;

    // EX-stage decode of the ID/EX instruction
    logic [3:0]  op_s;
    logic [2:0]  ra_s;
    logic [2:0]  rb_s;
    logic [2:0]  rc_s;
    logic        comp_s;
    logic [1:0]  cz_s;
    logic [15:0] se6_s;
    logic [15:0] b_eff_s;
    logic [16:0] add_sum_s;
    logic [16:0] adi_sum_s;
    logic [15:0] nand_s;
    logic [15:0] target_s;
    logic        cond_ok_s;

    // EX-stage next values
    logic [15:0] res_s;
    logic        wr_en_s;
    logic [2:0]  wr_addr_s;
    logic        c_next_s;
    logic        z_next_s;
    logic        take_s;

    assign op_s      = idex_instr_r[15:12];
    assign ra_s      = idex_instr_r[11:9];
    assign rb_s      = idex_instr_r[8:6];
    assign rc_s      = idex_instr_r[5:3];
    assign comp_s    = idex_instr_r[2];
    assign cz_s      = idex_instr_r[1:0];
    assign se6_s     = {{10{idex_instr_r[5]}}, idex_instr_r[5:0]};
    assign b_eff_s   = comp_s ? ~idex_b_r : idex_b_r;
    // cz=11 on the ADD family folds the registered carry in (AWC/ACW)
    assign add_sum_s = {1'b0, idex_a_r} + {1'b0, b_eff_s}
                     + {16'd0, ((cz_s == 2'b11) ? carry_r : 1'b0)};
    assign adi_sum_s = {1'b0, idex_a_r} + {1'b0, se6_s};
    assign nand_s    = ~(idex_a_r & b_eff_s);
    // Branch target is relative to the branch's own PC
    assign target_s  = idex_pc_r + se6_s;

    // Conditional-execution predicate from the already-updated registered flags
    always_comb begin
        cond_ok_s = 1'b1;
        case (cz_s)
            2'b10:   cond_ok_s = carry_r;
            2'b01:   cond_ok_s = zero_r;
            default: cond_ok_s = 1'b1;
        endcase
    end

    // ALU result, write-back control, flag update and branch decision
    always_comb begin
        res_s     = 16'd0;
        wr_en_s   = 1'b0;
        wr_addr_s = 3'd0;
        c_next_s  = carry_r;
        z_next_s  = zero_r;
        take_s    = 1'b0;
        if (idex_valid_r) begin
            case (op_s)
                4'b0000: begin
                    res_s     = adi_sum_s[15:0];
                    wr_en_s   = 1'b1;
                    wr_addr_s = rb_s;
                    c_next_s  = adi_sum_s[16];
                    z_next_s  = (adi_sum_s[15:0] == 16'd0);
                end
                4'b0001: begin
                    res_s     = add_sum_s[15:0];
                    wr_addr_s = rc_s;
                    if (cond_ok_s) begin
                        wr_en_s  = 1'b1;
                        c_next_s = add_sum_s[16];
                        z_next_s = (add_sum_s[15:0] == 16'd0);
                    end else begin
                        wr_en_s  = 1'b0;
                    end
                end
                4'b0010: begin
                    res_s     = nand_s;
                    wr_addr_s = rc_s;
                    if (cond_ok_s) begin
                        wr_en_s  = 1'b1;
                        z_next_s = (nand_s == 16'd0);
                    end else begin
                        wr_en_s  = 1'b0;
                    end
                end
                4'b0011: begin
                    res_s     = {7'd0, idex_instr_r[8:0]};
                    wr_en_s   = 1'b1;
                    wr_addr_s = ra_s;
                end
                4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                    // Effective address for the memory stage; no write-back here
                    res_s = idex_b_r + se6_s;
                end
                4'b1000: begin
                    res_s  = target_s;
                    take_s = (idex_a_r == idex_b_r);
                end
                4'b1001: begin
                    res_s  = target_s;
                    take_s = (idex_a_r < idex_b_r);
                end
                4'b1010: begin
                    res_s  = target_s;
                    take_s = (idex_a_r <= idex_b_r);
                end
                default: begin
                    res_s = 16'd0;
                end
            endcase
        end else begin
            take_s = 1'b0;
        end
    end

    // Pipeline registers, EX outputs and flags; a taken branch squashes IF/ID and ID/EX
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r           <= RESET_PC;
            ifid_instr_r   <= 16'd0;
            ifid_pc_r      <= 16'd0;
            ifid_valid_r   <= 1'b0;
            idex_instr_r   <= 16'd0;
            idex_pc_r      <= 16'd0;
            idex_a_r       <= 16'd0;
            idex_b_r       <= 16'd0;
            idex_valid_r   <= 1'b0;
            ex_valid_r     <= 1'b0;
            ex_instr_r     <= 16'd0;
            ex_result_r    <= 16'd0;
            ex_wr_en_r     <= 1'b0;
            ex_wr_addr_r   <= 3'd0;
            carry_r        <= 1'b0;
            zero_r         <= 1'b0;
            branch_taken_r <= 1'b0;
        end else begin
            ex_valid_r     <= idex_valid_r;
            ex_instr_r     <= idex_instr_r;
            ex_result_r    <= res_s;
            ex_wr_en_r     <= wr_en_s;
            ex_wr_addr_r   <= wr_addr_s;
            carry_r        <= c_next_s;
            zero_r         <= z_next_s;
            branch_taken_r <= take_s;
            if (take_s) begin
                pc_r         <= target_s;
                ifid_instr_r <= 16'd0;
                ifid_pc_r    <= 16'd0;
                ifid_valid_r <= 1'b0;
                idex_instr_r <= 16'd0;
                idex_pc_r    <= 16'd0;
                idex_a_r     <= 16'd0;
                idex_b_r     <= 16'd0;
                idex_valid_r <= 1'b0;
            end else begin
                pc_r         <= pc_r + 16'd1;
                ifid_instr_r <= bus.imem_data;
                ifid_pc_r    <= pc_r;
                ifid_valid_r <= 1'b1;
                idex_instr_r <= ifid_instr_r;
                idex_pc_r    <= ifid_pc_r;
                idex_a_r     <= bus.rf_data_a;
                idex_b_r     <= bus.rf_data_b;
                idex_valid_r <= ifid_valid_r;
            end
        end
    end

    assign bus.imem_addr    = pc_r;
    assign bus.rf_addr_a    = ifid_instr_r[11:9];
    assign bus.rf_addr_b    = ifid_instr_r[8:6];
    assign bus.ex_valid     = ex_valid_r;
    assign bus.ex_instr     = ex_instr_r;
    assign bus.ex_result    = ex_result_r;
    assign bus.ex_wr_en     = ex_wr_en_r;
    assign bus.ex_wr_addr   = ex_wr_addr_r;
    assign bus.carry_flag   = carry_r;
    assign bus.zero_flag    = zero_r;
    assign bus.branch_taken = branch_taken_r;

endmodule

// File: tb/tb_fetch_decode_alu_core.sv
// Directed testbench for fetch_decode_alu_core.
// Instruction memory and register file are modelled as tb arrays with
// combinational read; the register file is held constant (no write-back).
module tb_fetch_decode_alu_core;

    logic clock;
    logic reset;
    logic [15:0] imem [0:63];
    logic [15:0] rf   [0:7];
    int pass_cnt;
    int chk_cnt;

    fetch_decode_alu_core_if bus();

    assign bus.imem_data = imem[bus.imem_addr[5:0]];
    assign bus.rf_data_a = rf[bus.rf_addr_a];
    assign bus.rf_data_b = rf[bus.rf_addr_b];

    fetch_decode_alu_core #(.RESET_PC(16'h0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One posedge, then sample on the following negedge
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 16'hF000;
    endtask

    // Holds reset across two edges and releases it at a negedge
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_imem();
        imem[0] = 16'h1298;                       // ADA R3=R1+R2
        do_reset();
        chk_cnt++; if (bus.imem_addr !== 16'h0000) $display("FAIL rst_pc: got %h want %h", bus.imem_addr, 16'h0000); else pass_cnt++;
        chk_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.ex_valid); else pass_cnt++;
        repeat (3) tick();
        chk_cnt++; if (bus.carry_flag !== 1'b1) $display("FAIL pre_rst_c: got %b want 1", bus.carry_flag); else pass_cnt++;
        // Asynchronous assertion mid-cycle
        #2 reset = 1'b1;
        #1;
        chk_cnt++; if (bus.imem_addr !== 16'h0000) $display("FAIL async_pc: got %h want %h", bus.imem_addr, 16'h0000); else pass_cnt++;
        chk_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL async_valid: got %b want 0", bus.ex_valid); else pass_cnt++;
        chk_cnt++; if ({bus.carry_flag, bus.zero_flag, bus.branch_taken} !== 3'b000) $display("FAIL async_flags: got %b want 000", {bus.carry_flag, bus.zero_flag, bus.branch_taken}); else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk_cnt++; if (bus.imem_addr !== 16'h0001) $display("FAIL post_rst_pc: got %h want %h", bus.imem_addr, 16'h0001); else pass_cnt++;
        repeat (2) tick();
        chk_cnt++; if ({bus.ex_valid, bus.ex_instr} !== {1'b1, 16'h1298}) $display("FAIL post_rst_first: got %b/%h want 1/1298", bus.ex_valid, bus.ex_instr); else pass_cnt++;
    endtask

    task automatic test_add_family();
        clear_imem();
        imem[0] = 16'h1298;                       // ADA R3 = FFFF + 0001
        imem[1] = 16'h1977;                       // ACW R6 = 5 + ~2 + C
        do_reset();
        repeat (2) tick();
        chk_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL ada_latency: got %b want 0", bus.ex_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.ex_result !== 16'h0000) $display("FAIL ada_result: got %h want 0000", bus.ex_result); else pass_cnt++;
        chk_cnt++; if ({bus.carry_flag, bus.zero_flag} !== 2'b11) $display("FAIL ada_flags: got %b want 11", {bus.carry_flag, bus.zero_flag}); else pass_cnt++;
        chk_cnt++; if ({bus.ex_valid, bus.ex_wr_en, bus.ex_wr_addr} !== {1'b1, 1'b1, 3'd3}) $display("FAIL ada_wr: got %b%b/%0d want 11/3", bus.ex_valid, bus.ex_wr_en, bus.ex_wr_addr); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.ex_result !== 16'h0003) $display("FAIL acw_result: got %h want 0003", bus.ex_result); else pass_cnt++;
        chk_cnt++; if ({bus.carry_flag, bus.zero_flag} !== 2'b10) $display("FAIL acw_flags: got %b want 10", {bus.carry_flag, bus.zero_flag}); else pass_cnt++;
        chk_cnt++; if ({bus.ex_wr_en, bus.ex_wr_addr} !== {1'b1, 3'd6}) $display("FAIL acw_wr: got %b/%0d want 1/6", bus.ex_wr_en, bus.ex_wr_addr); else pass_cnt++;
    endtask

    task automatic test_conditional();
        clear_imem();
        imem[0] = 16'h1978;                       // ADA R7 = 5 + 2 -> C=0 Z=0
        imem[1] = 16'h12B2;                       // ADC (skipped, C=0)
        imem[2] = 16'h1298;                       // ADA -> C=1 Z=1
        imem[3] = 16'h12B2;                       // ADC (executes)
        do_reset();
        repeat (4) tick();
        chk_cnt++; if ({bus.ex_valid, bus.ex_wr_en} !== 2'b10) $display("FAIL adc_skip_wr: got %b%b want 10", bus.ex_valid, bus.ex_wr_en); else pass_cnt++;
        chk_cnt++; if ({bus.carry_flag, bus.zero_flag} !== 2'b00) $display("FAIL adc_skip_flags: got %b want 00", {bus.carry_flag, bus.zero_flag}); else pass_cnt++;
        repeat (2) tick();
        chk_cnt++; if ({bus.ex_wr_en, bus.ex_wr_addr, bus.ex_result} !== {1'b1, 3'd6, 16'h0000}) $display("FAIL adc_exec: got %b/%0d/%h want 1/6/0000", bus.ex_wr_en, bus.ex_wr_addr, bus.ex_result); else pass_cnt++;
        chk_cnt++; if ({bus.carry_flag, bus.zero_flag} !== 2'b11) $display("FAIL adc_exec_flags: got %b want 11", {bus.carry_flag, bus.zero_flag}); else pass_cnt++;
    endtask

    task automatic test_nand();
        clear_imem();
        imem[0] = 16'h1978;                       // C=0 Z=0
        imem[1] = 16'h2278;                       // NDU R7 = ~(FFFF & FFFF)
        imem[2] = 16'h1298;                       // C=1 Z=1
        imem[3] = 16'h2940;                       // NDU R0 = ~(5 & 2) = FFFF
        do_reset();
        repeat (4) tick();
        chk_cnt++; if ({bus.ex_result, bus.ex_wr_en, bus.ex_wr_addr} !== {16'h0000, 1'b1, 3'd7}) $display("FAIL ndu_zero: got %h/%b/%0d want 0000/1/7", bus.ex_result, bus.ex_wr_en, bus.ex_wr_addr); else pass_cnt++;
        chk_cnt++; if ({bus.carry_flag, bus.zero_flag} !== 2'b01) $display("FAIL ndu_zero_flags: got %b want 01", {bus.carry_flag, bus.zero_flag}); else pass_cnt++;
        repeat (2) tick();
        chk_cnt++; if (bus.ex_result !== 16'hFFFF) $display("FAIL ndu_ones: got %h want FFFF", bus.ex_result); else pass_cnt++;
        chk_cnt++; if ({bus.carry_flag, bus.zero_flag} !== 2'b10) $display("FAIL ndu_ones_flags: got %b want 10", {bus.carry_flag, bus.zero_flag}); else pass_cnt++;
    endtask

    task automatic test_imm_mem();
        clear_imem();
        imem[0] = 16'h0281;                       // ADI R2 = FFFF + 1
        imem[1] = 16'h3BA5;                       // LLI R5 = 01A5
        imem[2] = 16'h413E;                       // LW addr = R4 - 2
        imem[3] = 16'hF000;                       // unused opcode
        do_reset();
        repeat (3) tick();
        chk_cnt++; if ({bus.ex_result, bus.ex_wr_en, bus.ex_wr_addr, bus.carry_flag, bus.zero_flag} !== {16'h0000, 1'b1, 3'd2, 2'b11}) $display("FAIL adi: got %h/%b/%0d/%b%b want 0000/1/2/11", bus.ex_result, bus.ex_wr_en, bus.ex_wr_addr, bus.carry_flag, bus.zero_flag); else pass_cnt++;
        tick();
        chk_cnt++; if ({bus.ex_result, bus.ex_wr_en, bus.ex_wr_addr, bus.carry_flag, bus.zero_flag} !== {16'h01A5, 1'b1, 3'd5, 2'b11}) $display("FAIL lli: got %h/%b/%0d/%b%b want 01A5/1/5/11", bus.ex_result, bus.ex_wr_en, bus.ex_wr_addr, bus.carry_flag, bus.zero_flag); else pass_cnt++;
        tick();
        chk_cnt++; if ({bus.ex_result, bus.ex_wr_en} !== {16'h0003, 1'b0}) $display("FAIL lw_addr: got %h/%b want 0003/0", bus.ex_result, bus.ex_wr_en); else pass_cnt++;
        tick();
        chk_cnt++; if ({bus.ex_valid, bus.ex_result, bus.ex_wr_en} !== {1'b1, 16'h0000, 1'b0}) $display("FAIL other_op: got %b/%h/%b want 1/0000/0", bus.ex_valid, bus.ex_result, bus.ex_wr_en); else pass_cnt++;
    endtask

    task automatic test_branch();
        int seen;
        clear_imem();
        imem[2] = 16'h3002;
        imem[3] = 16'h3003;
        imem[4] = 16'h827E;                       // BEQ R1,R1,-2
        imem[5] = 16'h3005;
        imem[6] = 16'h3006;
        do_reset();
        repeat (7) tick();
        chk_cnt++; if ({bus.branch_taken, bus.ex_instr} !== {1'b1, 16'h827E}) $display("FAIL beq_taken: got %b/%h want 1/827E", bus.branch_taken, bus.ex_instr); else pass_cnt++;
        chk_cnt++; if (bus.imem_addr !== 16'h0002) $display("FAIL beq_target: got %h want 0002", bus.imem_addr); else pass_cnt++;
        chk_cnt++; if (bus.ex_wr_en !== 1'b0) $display("FAIL beq_wr: got %b want 0", bus.ex_wr_en); else pass_cnt++;
        tick();
        chk_cnt++; if ({bus.branch_taken, bus.ex_valid, bus.imem_addr} !== {2'b00, 16'h0003}) $display("FAIL beq_squash1: got %b%b/%h want 00/0003", bus.branch_taken, bus.ex_valid, bus.imem_addr); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL beq_squash2: got %b want 0", bus.ex_valid); else pass_cnt++;
        tick();
        chk_cnt++; if ({bus.ex_valid, bus.ex_instr} !== {1'b1, 16'h3002}) $display("FAIL beq_resume: got %b/%h want 1/3002", bus.ex_valid, bus.ex_instr); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ex_valid && (bus.ex_instr == 16'h3005 || bus.ex_instr == 16'h3006)) seen++;
        end
        chk_cnt++; if (seen !== 0) $display("FAIL beq_shadow: got %0d shadow executions want 0", seen); else pass_cnt++;
    endtask

    task automatic test_branch_cond();
        clear_imem();
        imem[0] = 16'h9942;                       // BLT R4(5) < R5(2): not taken
        imem[1] = 16'hAB02;                       // BLE R5(2) <= R4(5): taken, +2
        do_reset();
        repeat (3) tick();
        chk_cnt++; if ({bus.ex_valid, bus.branch_taken, bus.imem_addr} !== {2'b10, 16'h0003}) $display("FAIL blt_not_taken: got %b%b/%h want 10/0003", bus.ex_valid, bus.branch_taken, bus.imem_addr); else pass_cnt++;
        tick();
        chk_cnt++; if ({bus.branch_taken, bus.imem_addr} !== {1'b1, 16'h0003}) $display("FAIL ble_taken: got %b/%h want 1/0003", bus.branch_taken, bus.imem_addr); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        reset    = 1'b1;
        rf[0] = 16'h0000; rf[1] = 16'hFFFF; rf[2] = 16'h0001; rf[3] = 16'h0000;
        rf[4] = 16'h0005; rf[5] = 16'h0002; rf[6] = 16'h0000; rf[7] = 16'h0000;
        clear_imem();
        @(negedge clock);
        test_reset();
        test_add_family();
        test_conditional();
        test_nand();
        test_imm_mem();
        test_branch();
        test_branch_cond();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
